// File: rtl/int_ctrl_if.sv
// Bus between the interrupt controller and its CPU/peripheral side.
// master: the CPU/bench side that drives requests, STI/CLI, mask writes and handshakes.
// slave:  the controller.
interface int_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               sti;
  logic               cli;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               inta;
  logic               eoi;
  logic               interrupt;
  logic [7:0]         vector;
  logic               ie;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;

  modport master (
    output irq, sti, cli, mask_we, mask_wdata, inta, eoi,
    input  interrupt, vector, ie, pending, in_service
  );

  modport slave (
    input  irq, sti, cli, mask_we, mask_wdata, inta, eoi,
    output interrupt, vector, ie, pending, in_service
  );
endinterface

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller in front of the microprogrammed CPU.
// Latches request edges, arbitrates (bit 0 highest), raises a registered
// interrupt with an 8-bit vector and runs the INTA/EOI handshake.
// Build option: IRQ_LEVEL_EN -- pending mirrors irq levels instead of
// latching rising edges, and INTA does not clear it.
module int_ctrl #(
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input logic     clk,
  input logic     reset,
  int_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] idx_oh;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               grant;
  logic               ack;
  logic               done;
  logic               interrupt;
  logic               ie;
  logic [7:0]         vector;

`ifndef IRQ_LEVEL_EN
  logic [NUM_IRQ-1:0] rise;
  assign rise = bus.irq & ~irq_q;
`endif

  assign eligible = pending & ~mask;

  // Fixed-priority pick: scan downwards so the lowest set index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // One-hot decode of the latched source index.
  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) idx_oh[i] = (idx == IDX_W'(i));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: INTA beats CLI in REQ; stray INTA/EOI fall through untouched.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ie && grant_vld) state_n = REQ;
      REQ:     if (bus.inta)        state_n = SERVICE;
               else if (bus.cli)    state_n = IDLE;
      SERVICE: if (bus.eoi)         state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end

  // Per-state strobes that steer the datapath registers.
  always_comb begin
    grant = (state == IDLE) && ie && grant_vld;
    ack   = (state == REQ) && bus.inta;
    done  = (state == SERVICE) && bus.eoi;
  end

  // Datapath registers: edge latch, enable, mask, grant capture, service tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
      ie         <= 1'b0;
      interrupt  <= 1'b0;
      vector     <= VEC_BASE;
      idx        <= '0;
    end else begin
      irq_q <= bus.irq;
`ifdef IRQ_LEVEL_EN
      pending <= bus.irq;
`else
      // A fresh edge on the acknowledged source survives the INTA clear.
      pending <= (pending & ~(ack ? idx_oh : '0)) | rise;
`endif
      if (bus.mask_we) mask <= bus.mask_wdata;
      // Acknowledge acts as an implicit CLI; CLI beats STI.
      if (bus.cli || ack) ie <= 1'b0;
      else if (bus.sti)   ie <= 1'b1;
      interrupt <= (state_n == REQ);
      if (grant) begin
        idx    <= grant_idx;
        vector <= VEC_BASE + 8'(grant_idx);
      end
      if (ack)       in_service <= idx_oh;
      else if (done) in_service <= '0;
    end
  end

  assign bus.interrupt  = interrupt;
  assign bus.vector     = vector;
  assign bus.ie         = ie;
  assign bus.pending    = pending;
  assign bus.in_service = in_service;
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: expected vectors are queued when a request is
// stimulated and compared when the DUT raises interrupt; register state
// is checked directly after each step.
module tb_int_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic int_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  int_ctrl_if #(.NUM_IRQ(4)) bus();

  int_ctrl #(.NUM_IRQ(4), .VEC_BASE(8'h20)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sti();
    bus.sti = 1'b1; step(); bus.sti = 1'b0;
  endtask

  task automatic pulse_inta();
    bus.inta = 1'b1; step(); bus.inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    bus.irq = v; step(); bus.irq = 4'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_int"}, bus.interrupt, 0);
    chk({tag, "_vec"}, bus.vector, 8'h20);
    chk({tag, "_ie"}, bus.ie, 0);
    chk({tag, "_pend"}, bus.pending, 0);
    chk({tag, "_isr"}, bus.in_service, 0);
  endtask

  // Scoreboard side: each rising interrupt must match the oldest queued vector.
  always @(negedge clk) begin
    if (bus.interrupt && !int_prev) begin
      if (exp_q.size() == 0) chk("spurious_int", 1, 0);
      else begin
        exp_v = exp_q.pop_front();
        chk("sb_vector", bus.vector, exp_v);
      end
    end
    int_prev = bus.interrupt;
  end

  initial begin
    reset = 1'b1;
    bus.irq = '0; bus.sti = 0; bus.cli = 0; bus.mask_we = 0;
    bus.mask_wdata = '0; bus.inta = 0; bus.eoi = 0;
    step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Basic single request on source 2.
    pulse_sti();
    chk("t1_ie", bus.ie, 1);
    exp_q.push_back(8'h22);
    pulse_irq(4'b0100);
    chk("t1_pend", bus.pending, 4'b0100);
    chk("t1_int_lat", bus.interrupt, 0);
    step();
    chk("t1_int", bus.interrupt, 1);
    chk("t1_vec", bus.vector, 8'h22);
    pulse_inta();
    chk("t1_ack_int", bus.interrupt, 0);
    chk("t1_ack_isr", bus.in_service, 4'b0100);
    chk("t1_ack_ie", bus.ie, 0);
    chk("t1_ack_pend", bus.pending, 0);
    pulse_eoi();
    chk("t1_eoi_isr", bus.in_service, 0);

    // Two simultaneous sources: priority then the leftover.
    pulse_sti();
    exp_q.push_back(8'h21);
    pulse_irq(4'b1010);
    step();
    chk("t2_vec", bus.vector, 8'h21);
    chk("t2_pend", bus.pending, 4'b1010);
    pulse_inta();
    chk("t2_pend_ack", bus.pending, 4'b1000);
    chk("t2_isr", bus.in_service, 4'b0010);
    pulse_eoi();
    exp_q.push_back(8'h23);
    pulse_sti();
    step();
    chk("t2_int2", bus.interrupt, 1);
    chk("t2_vec2", bus.vector, 8'h23);
    pulse_inta();
    pulse_eoi();

    // Masked source stays pending until the mask is lifted.
    bus.mask_we = 1; bus.mask_wdata = 4'b0001; step(); bus.mask_we = 0;
    pulse_sti();
    pulse_irq(4'b0001);
    step(); step();
    chk("t3_masked_int", bus.interrupt, 0);
    chk("t3_masked_pend", bus.pending, 4'b0001);
    exp_q.push_back(8'h20);
    bus.mask_we = 1; bus.mask_wdata = 4'b0000; step(); bus.mask_we = 0;
    chk("t3_int_w", bus.interrupt, 0);
    step();
    chk("t3_int", bus.interrupt, 1);
    chk("t3_vec", bus.vector, 8'h20);
    pulse_inta();
    pulse_eoi();

    // CLI withdraws a raised request without losing it.
    pulse_sti();
    exp_q.push_back(8'h22);
    pulse_irq(4'b0100);
    step();
    chk("t4_vec", bus.vector, 8'h22);
    bus.cli = 1; step(); bus.cli = 0;
    chk("t4_cli_int", bus.interrupt, 0);
    chk("t4_cli_pend", bus.pending, 4'b0100);
    chk("t4_cli_ie", bus.ie, 0);
    exp_q.push_back(8'h22);
    pulse_sti();
    step();
    chk("t4_reint", bus.interrupt, 1);
    chk("t4_revec", bus.vector, 8'h22);
    pulse_inta();
    pulse_eoi();

    // Fresh edge in the same cycle as INTA on that source keeps it pending.
    pulse_sti();
    exp_q.push_back(8'h21);
    pulse_irq(4'b0010);
    step();
    chk("t5_vec", bus.vector, 8'h21);
    bus.inta = 1; bus.irq = 4'b0010; step(); bus.inta = 0; bus.irq = 4'b0;
    chk("t5_pend", bus.pending, 4'b0010);
    chk("t5_isr", bus.in_service, 4'b0010);
    pulse_eoi();
    exp_q.push_back(8'h21);
    pulse_sti();
    step();
    chk("t5_reint", bus.interrupt, 1);
    chk("t5_revec", bus.vector, 8'h21);
    pulse_inta();
    pulse_eoi();

    // Held level does not re-pend; stray INTA/EOI in IDLE are ignored.
    pulse_sti();
    exp_q.push_back(8'h20);
    bus.irq = 4'b0001; step();
    step();
    chk("t6_vec", bus.vector, 8'h20);
    pulse_inta();
    step();
    chk("t6_level_pend", bus.pending, 0);
    pulse_eoi();
    pulse_sti();
    step(); step();
    chk("t6_level_int", bus.interrupt, 0);
    pulse_inta();
    chk("t6_stray_ie", bus.ie, 1);
    chk("t6_stray_isr", bus.in_service, 0);
    pulse_eoi();
    chk("t6_stray_eoi_ie", bus.ie, 1);
    bus.irq = 4'b0;
    step();

    // Reset while in SERVICE with another source pending.
    exp_q.push_back(8'h22);
    pulse_irq(4'b0100);
    step();
    pulse_inta();
    pulse_irq(4'b1000);
    chk("t7_pend", bus.pending, 4'b1000);
    chk("t7_isr", bus.in_service, 4'b0100);
    reset = 1'b1; step(); reset = 1'b0;
    chk_reset_vals("t7_rst");
    step(); step();
    chk("t7_idle_int", bus.interrupt, 0);
    pulse_sti();
    step(); step();
    chk("t7_sti_int", bus.interrupt, 0);
    exp_q.push_back(8'h23);
    pulse_irq(4'b1000);
    step();
    chk("t7_int", bus.interrupt, 1);
    chk("t7_vec", bus.vector, 8'h23);
    pulse_inta();
    pulse_eoi();

    step();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
